axi4_master_ctrl: RTL
=====================

AXI4_MASTER_CTRL -- requirements
Module: axi4_master_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the AXI data bus width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 16, the AXI address width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic rises on its positive edge.
REQ-004 The block SHALL have port ARESETn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have cmd_valid/cmd_ready, in/out, 1/1 bit: command handshake.
REQ-006 The block SHALL have cmd_write/cmd_addr/cmd_len, in, 1/ADDR_WIDTH/8 bits: 1=write, start byte address, AXI beat count minus 1.
REQ-007 The block SHALL have wr_data/wr_valid/wr_ready, in/in/out, DATA_WIDTH/1/1 bits: write-data stream.
REQ-008 The block SHALL have rd_data/rd_valid/rd_last/rd_ready, out/out/out/in, DATA_WIDTH/1/1/1 bits: read-data stream.
REQ-009 The block SHALL have done/resp, out, 1/2 bits: one-cycle completion pulse and final AXI response.
REQ-010 The block SHALL have AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID/AWREADY: out, widths ADDR_WIDTH/8/3/2/1; AWREADY in, 1 bit.
REQ-011 The block SHALL have WDATA/WSTRB/WLAST/WVALID/WREADY: out, widths DATA_WIDTH/DATA_WIDTH/8/1/1; WREADY in, 1 bit.
REQ-012 The block SHALL have BRESP/BVALID in (2/1 bits) and BREADY out (1 bit).
REQ-013 The block SHALL have ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID: out, same widths as AW; ARREADY in, 1 bit.
REQ-014 The block SHALL have RDATA/RRESP/RLAST/RVALID in (DATA_WIDTH/2/1/1 bits) and RREADY out (1 bit).

Function
REQ-015 The FSM SHALL have states IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, ERR; one transaction is outstanding at a time.
REQ-016 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a cycle with cmd_valid && cmd_ready, and its fields are registered.
REQ-017 On acceptance, a command whose burst crosses a 4 KB boundary (cmd_addr[11:0] + (cmd_len+1)*DATA_WIDTH/8 > 4096) SHALL go to ERR, with no AXI traffic.
REQ-018 ERR SHALL last one cycle, pulse done=1 with resp=2'b10, and return to IDLE.
REQ-019 A legal write SHALL go to WR_ADDR and a legal read to RD_ADDR, with AxVALID=1 on the next cycle.
REQ-020 AxADDR SHALL equal cmd_addr with the low log2(DATA_WIDTH/8) bits cleared.
REQ-021 AxLEN SHALL equal cmd_len, AxSIZE SHALL equal log2(DATA_WIDTH/8), and AxBURST SHALL equal 2'b01 (INCR).
REQ-022 AxVALID and every AXI payload SHALL stay stable until AxREADY is sampled high; AxVALID SHALL then drop on the next cycle.
REQ-023 WR_ADDR SHALL pass to WR_DATA after the AW handshake; W beats SHALL NOT be issued before the AW handshake.
REQ-024 In WR_DATA, WVALID SHALL equal wr_valid, wr_ready SHALL equal WREADY, WDATA SHALL equal wr_data, and WSTRB SHALL be all ones; this path is combinational with zero added latency.
REQ-025 An 8-bit beat counter SHALL count W handshakes; WLAST SHALL be 1 exactly on beat cmd_len, and that beat SHALL move to WR_RESP.
REQ-026 In WR_RESP, BREADY SHALL be 1; on BVALID the block SHALL latch BRESP into resp, pulse done, and return to IDLE.
REQ-027 RD_ADDR SHALL pass to RD_DATA after the AR handshake.
REQ-028 In RD_DATA, rd_valid SHALL equal RVALID, RREADY SHALL equal rd_ready, rd_data SHALL equal RDATA, and rd_last SHALL equal RLAST.
REQ-029 During a read, resp SHALL accumulate the worst RRESP seen (numerically largest).
REQ-030 The R handshake with RLAST=1 SHALL pulse done on the next cycle and return to IDLE.
REQ-031 If RLAST arrives on a beat count other than cmd_len, resp SHALL be forced to 2'b10 and the FSM SHALL complete on that beat.
REQ-032 Outside their active states, wr_ready, rd_valid, WVALID, RREADY and BREADY SHALL be 0.
REQ-033 Back-to-back commands SHALL be supported: cmd_ready returns to 1 in the cycle after done.

Reset
REQ-034 On ARESETn=0 the block SHALL immediately force, asynchronously: FSM=IDLE, all VALID/READY outputs=0, done=0, resp=0, counter=0, all address/length/data outputs=0.
REQ-035 Reset asserted mid-burst SHALL abort the transaction with no done pulse.
REQ-036 After ARESETn=1, cmd_ready SHALL be 1 on the first clk edge.

Verification
REQ-037 Write with addr=0x0010 and len=3, four wr_data words, a slave with always-ready AW/W and BRESP=OKAY -> AWADDR=0x0010, AWLEN=3, AWBURST=1, WLAST on beat 4 only, then done with resp=0.
REQ-038 Read with addr=0x0100 and len=7, a slave returning 8 beats with RLAST on the 8th, and rd_ready toggled every other cycle -> 8 rd_data beats in order, then done with resp=0.
REQ-039 Write with addr=0x0FF8 and len=3 (crosses 4 KB) -> no AWVALID, done after 2 cycles with resp=2'b10.
REQ-040 Slave holds AWREADY=0 for 5 cycles -> AWADDR/AWLEN stay stable and no WVALID until the handshake.
REQ-041 Read where the slave asserts RLAST early on beat 2 with len=4 -> done with resp=2'b10, then FSM in IDLE.
REQ-042 ARESETn pulled low during beat 2 of an 8-beat write -> all outputs 0 in the same cycle, no done pulse, and a new command accepted after release.

Source files
------------

// File: rtl/axi4_master_ctrl_if.sv
// rtl/axi4_master_ctrl_if.sv - command, stream and AXI4 bus bundle for axi4_master_ctrl
interface axi4_master_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_write;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [7:0]              cmd_len;

    logic [DATA_WIDTH-1:0]   wr_data;
    logic                    wr_valid;
    logic                    wr_ready;

    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_valid;
    logic                    rd_last;
    logic                    rd_ready;

    logic                    done;
    logic [1:0]              resp;

    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    AWVALID;
    logic                    AWREADY;

    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;

    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;

    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic                    ARVALID;
    logic                    ARREADY;

    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        output cmd_ready,
        input  wr_data, wr_valid,
        output wr_ready,
        output rd_data, rd_valid, rd_last,
        input  rd_ready,
        output done, resp,
        output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY,
        output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  cmd_ready,
        output wr_data, wr_valid,
        input  wr_ready,
        input  rd_data, rd_valid, rd_last,
        output rd_ready,
        input  done, resp,
        input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY,
        input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi4_master_ctrl.sv
// rtl/axi4_master_ctrl.sv - single-outstanding AXI4 burst master driven by a command port
// Write/read data streams pass straight through to the W/R channels while their data state is active.
module axi4_master_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic            clk,
    input  logic            ARESETn,
    axi4_master_ctrl_if.master bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int SIZE  = $clog2(BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, ERR
    } state_t;

    state_t                r_state;
    logic                  r_cmd_ready;
    logic                  r_done;
    logic [1:0]            r_resp;
    logic [7:0]            r_len;
    logic [7:0]            r_beat;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [7:0]            r_awlen;
    logic                  r_awvalid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]            r_arlen;
    logic                  r_arvalid;
    logic [2:0]            r_axsize;
    logic [1:0]            r_axburst;

    logic        w_cmd_fire;
    logic [31:0] w_burst_end;
    logic        w_cross_4k;
    logic        w_in_wdata;
    logic        w_in_rdata;
    logic        w_w_fire;
    logic        w_r_fire;
    logic [1:0]  w_rresp_worst;

    assign w_cmd_fire  = bus.cmd_valid && r_cmd_ready;
    assign w_burst_end = 32'(bus.cmd_addr[11:0]) + (32'(bus.cmd_len) + 32'd1) * 32'(BYTES);
    assign w_cross_4k  = w_burst_end > 32'd4096;

    assign w_in_wdata = (r_state == WR_DATA);
    assign w_in_rdata = (r_state == RD_DATA);

    assign bus.WVALID   = w_in_wdata && bus.wr_valid;
    assign bus.wr_ready = w_in_wdata && bus.WREADY;
    assign bus.WDATA    = w_in_wdata ? bus.wr_data : '0;
    assign bus.WSTRB    = w_in_wdata ? '1 : '0;
    assign bus.WLAST    = w_in_wdata && (r_beat == r_len);
    assign w_w_fire     = bus.WVALID && bus.WREADY;

    assign bus.BREADY   = (r_state == WR_RESP);

    assign bus.rd_valid = w_in_rdata && bus.RVALID;
    assign bus.RREADY   = w_in_rdata && bus.rd_ready;
    assign bus.rd_data  = w_in_rdata ? bus.RDATA : '0;
    assign bus.rd_last  = w_in_rdata && bus.RLAST;
    assign w_r_fire     = bus.rd_valid && bus.RREADY;

    assign w_rresp_worst = (bus.RRESP > r_resp) ? bus.RRESP : r_resp;

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.done      = r_done;
    assign bus.resp      = r_resp;
    assign bus.AWADDR    = r_awaddr;
    assign bus.AWLEN     = r_awlen;
    assign bus.AWSIZE    = r_axsize;
    assign bus.AWBURST   = r_axburst;
    assign bus.AWVALID   = r_awvalid;
    assign bus.ARADDR    = r_araddr;
    assign bus.ARLEN     = r_arlen;
    assign bus.ARSIZE    = r_axsize;
    assign bus.ARBURST   = r_axburst;
    assign bus.ARVALID   = r_arvalid;

    // cmd_ready is held low for the done cycle so the next command lands one cycle later
    always_ff @(posedge clk or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_done      <= 1'b0;
            r_resp      <= 2'b00;
            r_len       <= 8'd0;
            r_beat      <= 8'd0;
            r_awaddr    <= '0;
            r_awlen     <= 8'd0;
            r_awvalid   <= 1'b0;
            r_araddr    <= '0;
            r_arlen     <= 8'd0;
            r_arvalid   <= 1'b0;
            r_axsize    <= 3'd0;
            r_axburst   <= 2'b00;
        end else begin
            r_done      <= 1'b0;
            r_cmd_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cmd_fire) begin
                        r_len  <= bus.cmd_len;
                        r_beat <= 8'd0;
                        r_resp <= 2'b00;
                        if (w_cross_4k) begin
                            r_state <= ERR;
                        end else if (bus.cmd_write) begin
                            r_state   <= WR_ADDR;
                            r_awaddr  <= bus.cmd_addr & ALIGN_MASK;
                            r_awlen   <= bus.cmd_len;
                            r_awvalid <= 1'b1;
                            r_axsize  <= 3'(SIZE);
                            r_axburst <= 2'b01;
                        end else begin
                            r_state   <= RD_ADDR;
                            r_araddr  <= bus.cmd_addr & ALIGN_MASK;
                            r_arlen   <= bus.cmd_len;
                            r_arvalid <= 1'b1;
                            r_axsize  <= 3'(SIZE);
                            r_axburst <= 2'b01;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                WR_ADDR: begin
                    if (bus.AWREADY) begin
                        r_awvalid <= 1'b0;
                        r_state   <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (w_w_fire) begin
                        r_beat <= r_beat + 8'd1;
                        if (r_beat == r_len) r_state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bus.BVALID) begin
                        r_resp  <= bus.BRESP;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                RD_ADDR: begin
                    if (bus.ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (w_r_fire) begin
                        r_beat <= r_beat + 8'd1;
                        r_resp <= w_rresp_worst;
                        if (bus.RLAST) begin
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                            // a premature RLAST means the slave truncated the burst
                            if (r_beat != r_len) r_resp <= 2'b10;
                        end
                    end
                end
                ERR: begin
                    r_resp  <= 2'b10;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
